// File: rtl/battleship_game_ctrl.sv
// Two-player battleship turn controller: ship placement for each player,
// alternating fire turns, hit tallies and winner detection.
module battleship_game_ctrl #(
  parameter int NUM_SHIPS   = 5,
  parameter int HITS_TO_WIN = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       place_valid,
  input  logic       fire_valid,
  input  logic       fire_hit,
  output logic [2:0] state,
  output logic [2:0] ship_count,
  output logic [4:0] p1_hits,
  output logic [4:0] p2_hits,
  output logic [1:0] winner,
  output logic       turn_done
);

  // state      | meaning
  // S_IDLE     | waiting for start
  // S_P1_PLACE | player 1 placing ships
  // S_P2_PLACE | player 2 placing ships
  // S_P1_FIRE  | player 1 to shoot
  // S_P2_FIRE  | player 2 to shoot
  // S_OVER     | game finished, winner held until start
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_P1_PLACE = 3'd1;
  localparam logic [2:0] S_P2_PLACE = 3'd2;
  localparam logic [2:0] S_P1_FIRE  = 3'd3;
  localparam logic [2:0] S_P2_FIRE  = 3'd4;
  localparam logic [2:0] S_OVER     = 3'd5;

  localparam logic [2:0] LAST_SHIP = 3'(NUM_SHIPS - 1);
  localparam logic [4:0] WIN_HITS  = 5'(HITS_TO_WIN);

  logic [2:0] state_q, state_d;
  logic [2:0] ship_q, ship_d;
  logic [4:0] p1_q, p1_d;
  logic [4:0] p2_q, p2_d;
  logic [1:0] win_q, win_d;
  logic       td_q, td_d;
  logic [4:0] p1_sat, p2_sat;

  // Saturating hit increments: counters stop at the winning count, never wrap.
  assign p1_sat = (p1_q >= WIN_HITS) ? WIN_HITS : p1_q + 5'd1;
  assign p2_sat = (p2_q >= WIN_HITS) ? WIN_HITS : p2_q + 5'd1;

  // Next-state and counter update; each state only honours its own input.
  always_comb begin
    state_d = state_q;
    ship_d  = ship_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    td_d    = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_P1_PLACE;
          ship_d  = '0;
          p1_d    = '0;
          p2_d    = '0;
          win_d   = '0;
        end
      end
      S_P1_PLACE, S_P2_PLACE: begin
        if (place_valid) begin
          if (ship_q == LAST_SHIP) begin
            ship_d  = '0;
            state_d = (state_q == S_P1_PLACE) ? S_P2_PLACE : S_P1_FIRE;
          end else begin
            ship_d = ship_q + 3'd1;
          end
        end
      end
      S_P1_FIRE: begin
        if (fire_valid) begin
          td_d    = 1'b1;
          state_d = S_P2_FIRE;
          if (fire_hit) begin
            p1_d = p1_sat;
            if (p1_sat == WIN_HITS) begin
              state_d = S_OVER;
              win_d   = 2'd1;
            end
          end
        end
      end
      S_P2_FIRE: begin
        if (fire_valid) begin
          td_d    = 1'b1;
          state_d = S_P1_FIRE;
          if (fire_hit) begin
            p2_d = p2_sat;
            if (p2_sat == WIN_HITS) begin
              state_d = S_OVER;
              win_d   = 2'd2;
            end
          end
        end
      end
      default: begin
        // Unused encodings recover to a clean idle.
        state_d = S_IDLE;
        ship_d  = '0;
        p1_d    = '0;
        p2_d    = '0;
        win_d   = '0;
      end
    endcase
  end

  // Registered game state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ship_q  <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      win_q   <= '0;
      td_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ship_q  <= ship_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      td_q    <= td_d;
    end
  end

  assign state      = state_q;
  assign ship_count = ship_q;
  assign p1_hits    = p1_q;
  assign p2_hits    = p2_q;
  assign winner     = win_q;
  assign turn_done  = td_q;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Bench for battleship_game_ctrl: a default-parameter instance and a
// HITS_TO_WIN=2 instance share stimulus; expected outputs are queued as
// each stimulus cycle is driven and popped when the outputs are sampled.
module tb_battleship_game_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, place_valid = 1'b0, fire_valid = 1'b0, fire_hit = 1'b0;

  logic [2:0] state_m, ship_m, state_w, ship_w;
  logic [4:0] p1_m, p2_m, p1_w, p2_w;
  logic [1:0] win_m, win_w;
  logic       td_m, td_w;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] sc;
    logic [4:0] h1;
    logic [4:0] h2;
    logic [1:0] w;
    logic       td;
  } obs_t;

  typedef struct packed {
    logic s, p, f, h;
    obs_t m;
    obs_t w;
  } row_t;

  obs_t exp_m_q[$];
  obs_t exp_w_q[$];

  always #5 clk = ~clk;

  battleship_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .place_valid(place_valid),
    .fire_valid(fire_valid), .fire_hit(fire_hit), .state(state_m),
    .ship_count(ship_m), .p1_hits(p1_m), .p2_hits(p2_m), .winner(win_m),
    .turn_done(td_m)
  );

  battleship_game_ctrl #(.NUM_SHIPS(5), .HITS_TO_WIN(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .place_valid(place_valid),
    .fire_valid(fire_valid), .fire_hit(fire_hit), .state(state_w),
    .ship_count(ship_w), .p1_hits(p1_w), .p2_hits(p2_w), .winner(win_w),
    .turn_done(td_w)
  );

  function automatic obs_t o(int st, int sc, int h1, int h2, int w, int td);
    obs_t x;
    x.st = 3'(st); x.sc = 3'(sc); x.h1 = 5'(h1); x.h2 = 5'(h2);
    x.w = 2'(w); x.td = 1'(td);
    return x;
  endfunction

  function automatic row_t r(logic s, logic p, logic f, logic h, obs_t m, obs_t w);
    row_t x;
    x.s = s; x.p = p; x.f = f; x.h = h; x.m = m; x.w = w;
    return x;
  endfunction

  function automatic obs_t obs_m();
    obs_t x;
    x.st = state_m; x.sc = ship_m; x.h1 = p1_m; x.h2 = p2_m; x.w = win_m; x.td = td_m;
    return x;
  endfunction

  function automatic obs_t obs_w();
    obs_t x;
    x.st = state_w; x.sc = ship_w; x.h1 = p1_w; x.h2 = p2_w; x.w = win_w; x.td = td_w;
    return x;
  endfunction

  // Called at a falling edge: hold inputs across one rising edge, then clear.
  task automatic step(input logic s, input logic p, input logic f, input logic h);
    start = s; place_valid = p; fire_valid = f; fire_hit = h;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; place_valid = 1'b0; fire_valid = 1'b0; fire_hit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_m() !== o(0,0,0,0,0,0)) begin
      failures++;
      $display("FAIL reset_dut got=%h want=%h", obs_m(), o(0,0,0,0,0,0));
    end
    checks++;
    if (obs_w() !== o(0,0,0,0,0,0)) begin
      failures++;
      $display("FAIL reset_dut_w got=%h want=%h", obs_w(), o(0,0,0,0,0,0));
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_placement();
    row_t t[$];
    obs_t em, ew;
    t.push_back(r(1,0,0,0, o(1,0,0,0,0,0), o(1,0,0,0,0,0)));
    t.push_back(r(0,0,1,1, o(1,0,0,0,0,0), o(1,0,0,0,0,0)));
    for (int i = 1; i <= 4; i++) t.push_back(r(0,1,0,0, o(1,i,0,0,0,0), o(1,i,0,0,0,0)));
    t.push_back(r(0,1,0,0, o(2,0,0,0,0,0), o(2,0,0,0,0,0)));
    t.push_back(r(1,0,0,0, o(2,0,0,0,0,0), o(2,0,0,0,0,0)));
    t.push_back(r(0,0,1,0, o(2,0,0,0,0,0), o(2,0,0,0,0,0)));
    for (int i = 1; i <= 4; i++) t.push_back(r(0,1,0,0, o(2,i,0,0,0,0), o(2,i,0,0,0,0)));
    t.push_back(r(0,1,0,0, o(3,0,0,0,0,0), o(3,0,0,0,0,0)));
    foreach (t[i]) begin
      exp_m_q.push_back(t[i].m);
      exp_w_q.push_back(t[i].w);
      step(t[i].s, t[i].p, t[i].f, t[i].h);
      em = exp_m_q.pop_front();
      ew = exp_w_q.pop_front();
      checks++;
      if (obs_m() !== em) begin
        failures++;
        $display("FAIL placement[%0d] dut got=%h want=%h", i, obs_m(), em);
      end
      checks++;
      if (obs_w() !== ew) begin
        failures++;
        $display("FAIL placement[%0d] dut_w got=%h want=%h", i, obs_w(), ew);
      end
    end
  endtask

  task automatic test_alternation();
    row_t t[$];
    obs_t em, ew;
    t.push_back(r(0,0,1,0, o(4,0,0,0,0,1), o(4,0,0,0,0,1)));
    t.push_back(r(0,0,0,0, o(4,0,0,0,0,0), o(4,0,0,0,0,0)));
    t.push_back(r(0,0,1,1, o(3,0,0,1,0,1), o(3,0,0,1,0,1)));
    t.push_back(r(0,0,0,0, o(3,0,0,1,0,0), o(3,0,0,1,0,0)));
    t.push_back(r(0,1,0,0, o(3,0,0,1,0,0), o(3,0,0,1,0,0)));
    t.push_back(r(1,0,0,0, o(3,0,0,1,0,0), o(3,0,0,1,0,0)));
    foreach (t[i]) begin
      exp_m_q.push_back(t[i].m);
      exp_w_q.push_back(t[i].w);
      step(t[i].s, t[i].p, t[i].f, t[i].h);
      em = exp_m_q.pop_front();
      ew = exp_w_q.pop_front();
      checks++;
      if (obs_m() !== em) begin
        failures++;
        $display("FAIL alternation[%0d] dut got=%h want=%h", i, obs_m(), em);
      end
      checks++;
      if (obs_w() !== ew) begin
        failures++;
        $display("FAIL alternation[%0d] dut_w got=%h want=%h", i, obs_w(), ew);
      end
    end
  endtask

  task automatic test_win();
    row_t t[$];
    obs_t em, ew;
    t.push_back(r(0,0,1,1, o(4,0,1,1,0,1), o(4,0,1,1,0,1)));
    t.push_back(r(0,0,1,0, o(3,0,1,1,0,1), o(3,0,1,1,0,1)));
    t.push_back(r(0,0,1,1, o(4,0,2,1,0,1), o(5,0,2,1,1,1)));
    t.push_back(r(0,0,1,0, o(3,0,2,1,0,1), o(5,0,2,1,1,0)));
    t.push_back(r(0,0,1,1, o(4,0,3,1,0,1), o(5,0,2,1,1,0)));
    t.push_back(r(0,1,0,0, o(4,0,3,1,0,0), o(5,0,2,1,1,0)));
    foreach (t[i]) begin
      exp_m_q.push_back(t[i].m);
      exp_w_q.push_back(t[i].w);
      step(t[i].s, t[i].p, t[i].f, t[i].h);
      em = exp_m_q.pop_front();
      ew = exp_w_q.pop_front();
      checks++;
      if (obs_m() !== em) begin
        failures++;
        $display("FAIL win[%0d] dut got=%h want=%h", i, obs_m(), em);
      end
      checks++;
      if (obs_w() !== ew) begin
        failures++;
        $display("FAIL win[%0d] dut_w got=%h want=%h", i, obs_w(), ew);
      end
    end
  endtask

  // dut_w restarts from GAME_OVER while dut (mid-fire) must ignore start.
  task automatic test_restart();
    obs_t em, ew;
    exp_m_q.push_back(o(4,0,3,1,0,0));
    exp_w_q.push_back(o(1,0,0,0,0,0));
    step(1,0,0,0);
    em = exp_m_q.pop_front();
    ew = exp_w_q.pop_front();
    checks++;
    if (obs_m() !== em) begin
      failures++;
      $display("FAIL restart_midgame_ignored got=%h want=%h", obs_m(), em);
    end
    checks++;
    if (obs_w() !== ew) begin
      failures++;
      $display("FAIL restart_from_over got=%h want=%h", obs_w(), ew);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_m() !== o(0,0,0,0,0,0)) begin
      failures++;
      $display("FAIL reset_async_dut got=%h want=%h", obs_m(), o(0,0,0,0,0,0));
    end
    checks++;
    if (obs_w() !== o(0,0,0,0,0,0)) begin
      failures++;
      $display("FAIL reset_async_dut_w got=%h want=%h", obs_w(), o(0,0,0,0,0,0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    row_t t[$];
    obs_t em, ew;
    t.push_back(r(0,1,1,1, o(0,0,0,0,0,0), o(0,0,0,0,0,0)));
    t.push_back(r(1,0,0,0, o(1,0,0,0,0,0), o(1,0,0,0,0,0)));
    for (int i = 1; i <= 4; i++) t.push_back(r(0,1,0,0, o(1,i,0,0,0,0), o(1,i,0,0,0,0)));
    t.push_back(r(0,1,0,0, o(2,0,0,0,0,0), o(2,0,0,0,0,0)));
    for (int i = 1; i <= 4; i++) t.push_back(r(0,1,0,0, o(2,i,0,0,0,0), o(2,i,0,0,0,0)));
    t.push_back(r(0,1,0,0, o(3,0,0,0,0,0), o(3,0,0,0,0,0)));
    t.push_back(r(0,0,1,1, o(4,0,1,0,0,1), o(4,0,1,0,0,1)));
    t.push_back(r(0,0,1,1, o(3,0,1,1,0,1), o(3,0,1,1,0,1)));
    t.push_back(r(0,0,1,0, o(4,0,1,1,0,1), o(4,0,1,1,0,1)));
    t.push_back(r(0,0,1,1, o(3,0,1,2,0,1), o(5,0,1,2,2,1)));
    t.push_back(r(0,0,1,1, o(4,0,2,2,0,1), o(5,0,1,2,2,0)));
    foreach (t[i]) begin
      exp_m_q.push_back(t[i].m);
      exp_w_q.push_back(t[i].w);
      step(t[i].s, t[i].p, t[i].f, t[i].h);
      em = exp_m_q.pop_front();
      ew = exp_w_q.pop_front();
      checks++;
      if (obs_m() !== em) begin
        failures++;
        $display("FAIL back_to_back[%0d] dut got=%h want=%h", i, obs_m(), em);
      end
      checks++;
      if (obs_w() !== ew) begin
        failures++;
        $display("FAIL back_to_back[%0d] dut_w got=%h want=%h", i, obs_w(), ew);
      end
    end
  endtask

  initial begin
    test_reset();
    test_placement();
    test_alternation();
    test_win();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/battleship_game_ctrl.md
BATTLESHIP_GAME_CTRL -- requirements
Module: battleship_game_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SHIPS, default 5: ship placements each player completes before firing begins (range 1-7).
REQ-002 The block SHALL have parameter HITS_TO_WIN, default 17: hit count that ends the game (range 1-31).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins a game.
REQ-006 The block SHALL have port place_valid, input, 1 bit: single-cycle pulse meaning the current player's ship placement was accepted.
REQ-007 The block SHALL have port fire_valid, input, 1 bit: single-cycle pulse meaning the current player's shot was resolved.
REQ-008 The block SHALL have port fire_hit, input, 1 bit: shot result, sampled only when fire_valid=1 (1 = hit).
REQ-009 The block SHALL have port state, output, 3 bits: game state encoding, consumed by the placement-enable decoder.
REQ-010 The block SHALL have port ship_count, output, 3 bits: placements completed by the current placing player.
REQ-011 The block SHALL have port p1_hits, output, 5 bits: hits scored by player 1.
REQ-012 The block SHALL have port p2_hits, output, 5 bits: hits scored by player 2.
REQ-013 The block SHALL have port winner, output, 2 bits: 0 = none, 1 = player 1, 2 = player 2.
REQ-014 The block SHALL have port turn_done, output, 1 bit: one-cycle pulse on every accepted fire_valid.

Function
REQ-015 State encoding SHALL be 0 IDLE, 1 P1_PLACE, 2 P2_PLACE, 3 P1_FIRE, 4 P2_FIRE, 5 GAME_OVER.
REQ-016 The state register SHALL drive state directly, with no combinational decode between register and port.
REQ-017 In IDLE, start=1 SHALL move to P1_PLACE on the next edge; all other inputs SHALL be ignored.
REQ-018 In P1_PLACE or P2_PLACE, place_valid SHALL increment ship_count when ship_count < NUM_SHIPS-1.
REQ-019 A place_valid arriving with ship_count = NUM_SHIPS-1 SHALL clear ship_count and advance the state: P1_PLACE -> P2_PLACE, P2_PLACE -> P1_FIRE.
REQ-020 fire_valid SHALL be ignored in both placement states.
REQ-021 In P1_FIRE, fire_valid with fire_hit=1 SHALL increment p1_hits.
REQ-022 In P1_FIRE, if the increment makes p1_hits equal HITS_TO_WIN, the state SHALL go to GAME_OVER and winner SHALL be set to 1 on the same edge.
REQ-023 In P1_FIRE, any other accepted fire_valid (miss, or hit that does not reach HITS_TO_WIN) SHALL move the state to P2_FIRE.
REQ-024 P2_FIRE SHALL behave as P1_FIRE with p2_hits, winner=2 on reaching HITS_TO_WIN, and P1_FIRE as the next state.
REQ-025 place_valid SHALL be ignored in both fire states.
REQ-026 turn_done SHALL be registered and assert for exactly one cycle after every fire_valid accepted in P1_FIRE or P2_FIRE.
REQ-027 turn_done SHALL NOT assert for fire_valid in any other state.
REQ-028 GAME_OVER SHALL hold state, hit counters and winner until start.
REQ-029 start in GAME_OVER SHALL clear p1_hits, p2_hits, winner and ship_count, and move to P1_PLACE.
REQ-030 start in states 1-4 SHALL be ignored; there is no mid-game restart.
REQ-031 Inputs SHALL be prioritised start > fire_valid > place_valid; only the input valid in the current state has effect.
REQ-032 Hit counters SHALL saturate at HITS_TO_WIN and never wrap.
REQ-033 Unused state codes 6 and 7 SHALL return to IDLE on the next edge, with all counters cleared.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=0, ship_count=0, p1_hits=0, p2_hits=0, winner=0 and turn_done=0.
REQ-035 Reset SHALL apply in any state, including mid-placement and mid-fire.
REQ-036 After rst_n deasserts, the first active edge SHALL evaluate inputs from IDLE.

Verification
REQ-037 Placement flow: reset, start, then 5 place_valid pulses -> state 1 with ship_count stepping 0->4, then state 2 with ship_count=0; 5 more pulses -> state 3.
REQ-038 Alternation: in state 3, fire_valid with fire_hit=0 -> state 4, turn_done one cycle, p1_hits=0; then fire_valid with fire_hit=1 -> state 3, p2_hits=1.
REQ-039 Win: HITS_TO_WIN=2, P1 hits on two consecutive P1 turns -> state 5, winner=1, p1_hits=2; further fire_valid changes nothing and gives no turn_done.
REQ-040 Ignored inputs: fire_valid during state 1 -> no change; place_valid during state 3 -> no change; start during state 2 -> no change.
REQ-041 Reset mid-operation: rst_n low in state 4 with p1_hits=3 -> all outputs 0 before the next clk edge.
REQ-042 Restart: start in state 5 -> next cycle state=1, hits, winner and ship_count all 0.
